// File: rtl/pi_lane_scheduler.sv
// pi_lane_scheduler: runs enabled PI lanes in ascending order over one shared operand bus per time step
module pi_lane_scheduler #(
  parameter int N_CH    = 4,
  parameter int W       = 64,
  parameter int LEAD    = 15,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_sta,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH*W-1:0] x_in,
  output logic [W-1:0]      x_out,
  output logic [N_CH-1:0]   read_x,
  output logic [N_CH-1:0]   sta_out,
  input  logic [N_CH-1:0]   done_in,
  input  logic [N_CH*W-1:0] y_in,
  output logic [N_CH*W-1:0] y_out,
  output logic [N_CH-1:0]   y_valid,
  output logic              busy,
  output logic              step_done,
  output logic [N_CH-1:0]   timeout_err,
  output logic              overrun
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int MX = LEAD > TIMEOUT ? LEAD : TIMEOUT;
  localparam int NW = $clog2(MX + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LOAD, S_LEAD, S_FIRE, S_WAIT, S_CAPTURE, S_FINISH
  } state_t;
  state_t state, state_n;
  logic [N_CH-1:0] pending;
  logic [CW-1:0]   cur, sel;
  logic [NW-1:0]   cnt;
  assign busy = !rst && state != S_IDLE;
  // lowest pending lane wins so lanes are served in ascending order
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (pending[i]) sel = CW'(i);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  // next state and one-cycle strobes; strobes are forced low during reset
  always_comb begin
    state_n   = state;
    read_x    = '0;
    sta_out   = '0;
    step_done = 1'b0;
    if (!rst)
      case (state)
        S_IDLE:    state_n = step_sta ? S_SELECT : S_IDLE;
        S_SELECT:  state_n = pending == '0 ? S_FINISH : S_LOAD;
        S_LOAD:    begin read_x[cur] = 1'b1; state_n = S_LEAD; end
        S_LEAD:    state_n = cnt == NW'(LEAD - 1) ? S_FIRE : S_LEAD;
        S_FIRE:    begin sta_out[cur] = 1'b1; state_n = S_WAIT; end
        S_WAIT:    state_n = done_in[cur] ? S_CAPTURE : cnt == NW'(TIMEOUT) ? S_SELECT : S_WAIT;
        S_CAPTURE: state_n = S_SELECT;
        S_FINISH:  begin step_done = 1'b1; state_n = S_IDLE; end
      endcase
  end
  // lane bookkeeping, operand bus, result bank and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      cur         <= '0;
      cnt         <= '0;
      x_out       <= '0;
      y_out       <= '0;
      y_valid     <= '0;
      timeout_err <= '0;
      overrun     <= 1'b0;
    end else begin
      if (step_sta && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (step_sta) begin
          pending <= ch_req;
          y_valid <= '0;
        end
        S_SELECT: if (pending != '0) begin
          cur   <= sel;
          x_out <= x_in[sel*W +: W];
        end
        S_LOAD: cnt <= NW'(1);
        S_LEAD: cnt <= cnt + 1'b1;
        S_FIRE: cnt <= '0;
        S_WAIT: if (!done_in[cur]) begin
          if (cnt == NW'(TIMEOUT)) begin
            timeout_err[cur] <= 1'b1;
            pending[cur]     <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        S_CAPTURE: begin
          y_out[cur*W +: W] <= y_in[cur*W +: W];
          y_valid[cur]      <= 1'b1;
          pending[cur]      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pi_lane_scheduler.sv
// tb_pi_lane_scheduler: randomized scenarios against a cycle-timeline model of the lane scheduler
module tb_pi_lane_scheduler;
  localparam int N = 4, W = 64, LEAD = 15, TO = 63, MAXC = 1024;
  logic clk = 0, rst = 1, step_sta = 0;
  logic [N-1:0] ch_req = '0, done_in = '0;
  logic [N*W-1:0] x_in = '0, y_in = '0;
  logic [W-1:0] x_out;
  logic [N-1:0] read_x, sta_out, y_valid, timeout_err;
  logic [N*W-1:0] y_out;
  logic busy, step_done, overrun;
  int checks = 0, fails = 0;
  int lane_d [N];
  logic [W-1:0] lane_x [N], lane_y [N];
  logic [W-1:0] m_y [N];
  logic [N-1:0] m_valid = '0, m_to = '0;
  logic m_ov = 0;
  logic [N-1:0] e_rx [MAXC], e_sta [MAXC];
  logic e_done [MAXC], e_busy [MAXC], e_xc [MAXC];
  logic [W-1:0] e_x [MAXC];
  int fin;

  always #5 clk = ~clk;

  pi_lane_scheduler #(.N_CH(N), .W(W), .LEAD(LEAD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .step_sta(step_sta), .ch_req(ch_req), .x_in(x_in),
    .x_out(x_out), .read_x(read_x), .sta_out(sta_out), .done_in(done_in),
    .y_in(y_in), .y_out(y_out), .y_valid(y_valid), .busy(busy),
    .step_done(step_done), .timeout_err(timeout_err), .overrun(overrun)
  );

  // expected timeline: each lane costs select, load, LEAD-1 lead cycles, fire, wait, capture
  task automatic build(input logic [N-1:0] req);
    int t, s, e, st;
    for (int c = 0; c < MAXC; c++) begin
      e_rx[c] = '0; e_sta[c] = '0; e_done[c] = 0; e_busy[c] = 0; e_xc[c] = 0; e_x[c] = '0;
    end
    m_valid = '0;
    t = 1;
    for (int i = 0; i < N; i++) if (req[i]) begin
      st = t + 1;
      s = st + LEAD;
      e_rx[st][i] = 1'b1;
      e_sta[s][i] = 1'b1;
      if (lane_d[i] >= 1 && lane_d[i] <= TO + 1) begin
        e = s + lane_d[i];
        m_y[i] = lane_y[i];
        m_valid[i] = 1'b1;
        t = e + 2;
      end else begin
        e = s + TO + 1;
        m_to[i] = 1'b1;
        t = e + 1;
      end
      for (int c = st; c <= e; c++) begin e_xc[c] = 1; e_x[c] = lane_x[i]; end
    end
    fin = t + 1;
    e_done[fin] = 1;
    for (int c = 1; c <= fin; c++) e_busy[c] = 1;
  endtask

  task automatic run_step(input logic [N-1:0] req, input int ovr_in, input int rst_c);
    int due [N];
    int lim, ovr_c;
    build(req);
    ovr_c = ovr_in == -2 ? fin : ovr_in;
    for (int i = 0; i < N; i++) begin
      due[i] = -1;
      x_in[i*W +: W] = lane_x[i];
      y_in[i*W +: W] = lane_y[i];
    end
    ch_req = req;
    lim = rst_c >= 0 ? rst_c + 30 : fin + 3;
    for (int c = 0; c <= lim; c++) begin
      step_sta = (c == 0) || (c == ovr_c);
      rst = (c == rst_c);
      if (c > 0) ch_req = N'($urandom);
      for (int i = 0; i < N; i++) done_in[i] = (due[i] == c);
      @(negedge clk);
      if (rst_c < 0 || c < rst_c) begin
        checks += 4;
        if (read_x !== e_rx[c]) begin fails++; $display("FAIL read_x cyc %0d: got %b exp %b", c, read_x, e_rx[c]); end
        if (sta_out !== e_sta[c]) begin fails++; $display("FAIL sta_out cyc %0d: got %b exp %b", c, sta_out, e_sta[c]); end
        if (step_done !== e_done[c]) begin fails++; $display("FAIL step_done cyc %0d: got %b exp %b", c, step_done, e_done[c]); end
        if (busy !== e_busy[c]) begin fails++; $display("FAIL busy cyc %0d: got %b exp %b", c, busy, e_busy[c]); end
        if (e_xc[c]) begin
          checks++;
          if (x_out !== e_x[c]) begin fails++; $display("FAIL x_out cyc %0d: got %h exp %h", c, x_out, e_x[c]); end
        end
      end else if (c == rst_c + 1) begin
        checks++;
        if ({read_x, sta_out, step_done, busy, x_out, y_out, y_valid, timeout_err, overrun} !== '0) begin
          fails++;
          $display("FAIL after_reset cyc %0d: rx %b sta %b dn %b bz %b x %h yv %b to %b ov %b exp all 0",
                   c, read_x, sta_out, step_done, busy, x_out, y_valid, timeout_err, overrun);
        end
      end else if (c > rst_c + 1) begin
        checks++;
        if ({read_x, sta_out, step_done, busy} !== '0) begin
          fails++;
          $display("FAIL idle_after_reset cyc %0d: rx %b sta %b dn %b bz %b exp 0", c, read_x, sta_out, step_done, busy);
        end
      end
      for (int i = 0; i < N; i++) if (sta_out[i] && lane_d[i] > 0) due[i] = c + lane_d[i];
      @(posedge clk); #1;
    end
    step_sta = 0; rst = 0; done_in = '0;
    if (ovr_c >= 0) m_ov = 1;
    if (rst_c >= 0) begin
      for (int i = 0; i < N; i++) m_y[i] = '0;
      m_valid = '0; m_to = '0; m_ov = 0;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (y_out[i*W +: W] !== m_y[i]) begin fails++; $display("FAIL y_out[%0d]: got %h exp %h", i, y_out[i*W +: W], m_y[i]); end
    end
    checks += 3;
    if (y_valid !== m_valid) begin fails++; $display("FAIL y_valid: got %b exp %b", y_valid, m_valid); end
    if (timeout_err !== m_to) begin fails++; $display("FAIL timeout_err: got %b exp %b", timeout_err, m_to); end
    if (overrun !== m_ov) begin fails++; $display("FAIL overrun: got %b exp %b", overrun, m_ov); end
  endtask

  task automatic rand_lanes(input int dmin, input int dmax);
    for (int i = 0; i < N; i++) begin
      lane_d[i] = $urandom_range(dmax, dmin);
      lane_x[i] = {$urandom, $urandom};
      lane_y[i] = {$urandom, $urandom};
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({read_x, sta_out, step_done, busy, x_out, y_out, y_valid, timeout_err, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: rx %b sta %b dn %b bz %b yv %b to %b ov %b exp all 0",
               read_x, sta_out, step_done, busy, y_valid, timeout_err, overrun);
    end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < N; i++) m_y[i] = '0;
  endtask

  task automatic test_single;
    rand_lanes(1, 40);
    lane_d[0] = 30;
    lane_x[0] = 64'h4000000000000000;
    lane_y[0] = 64'h4008000000000000;
    run_step(4'b0001, -1, -1);
  endtask

  task automatic test_all_lanes;
    rand_lanes(1, 40);
    run_step(4'b1111, -1, -1);
  endtask

  task automatic test_timeout;
    rand_lanes(1, 40);
    lane_d[2] = 0;
    run_step(4'b0110, -1, -1);
  endtask

  task automatic test_timeout_boundary;
    rand_lanes(1, 40);
    lane_d[0] = TO + 1;
    lane_d[1] = TO + 2;
    run_step(4'b0011, -1, -1);
  endtask

  task automatic test_empty;
    rand_lanes(1, 40);
    run_step(4'b0000, -1, -1);
  endtask

  task automatic test_overrun_wait;
    rand_lanes(5, 40);
    run_step(4'b0011, 2 + LEAD + 3, -1);
  endtask

  task automatic test_overrun_finish;
    rand_lanes(1, 40);
    lane_d[0] = 3;
    run_step(4'b0001, -2, -1);
  endtask

  task automatic test_reset_mid;
    rand_lanes(1, 40);
    lane_d[0] = 5;
    lane_d[1] = 10;
    run_step(4'b0011, -1, 30);
  endtask

  task automatic test_after_reset;
    rand_lanes(1, 40);
    run_step(4'b1010, -1, -1);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++) begin
      rand_lanes(1, 70);
      run_step(N'($urandom), -1, -1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_all_lanes;
    test_timeout;
    test_timeout_boundary;
    test_empty;
    test_overrun_wait;
    test_overrun_finish;
    test_reset_mid;
    test_after_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
